dispatch_router: RTL

- Sits between map_dispatch and the reservation stations.
- Accepts one dispatched instruction per cycle into a 1-entry holding register, classifies it by opcode and steers it to the LSU reservation station or to one of NUM_ALU_RS ALU reservation stations.
- ALU stations are shared round-robin, skipping full ones.
- Generates the RS stall that holds the upstream dispatch stage.

---
 rtl/dispatch_router_if.sv | 45 ++++
 rtl/dispatch_router.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dispatch_router_if.sv
// Bundle between map_dispatch, the dispatch router and the reservation
// stations.
//   Upstream side : i_flush, i_dispatch_en/opcode/pc/insn/dst_tag in,
//                   o_dispatch_stall back to map_dispatch.
//   Station side  : i_alu_rs_full/i_lsu_rs_full in, o_alu_rs_en/o_lsu_rs_en
//                   enqueue strobes plus the shared o_rs_* payload bus out.
// slave  : the router itself.
// master : whatever drives the router (map_dispatch + stations, or a bench).
interface dispatch_router_if #(
  parameter int NUM_ALU_RS   = 2,
  parameter int OPCODE_WIDTH = 7,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6
);
  logic                    i_flush;
  logic                    i_dispatch_en;
  logic [OPCODE_WIDTH-1:0] i_dispatch_opcode;
  logic [ADDR_WIDTH-1:0]   i_dispatch_pc;
  logic [DATA_WIDTH-1:0]   i_dispatch_insn;
  logic [TAG_WIDTH-1:0]    i_dispatch_dst_tag;
  logic [NUM_ALU_RS-1:0]   i_alu_rs_full;
  logic                    i_lsu_rs_full;
  logic                    o_dispatch_stall;
  logic [NUM_ALU_RS-1:0]   o_alu_rs_en;
  logic                    o_lsu_rs_en;
  logic [OPCODE_WIDTH-1:0] o_rs_opcode;
  logic [ADDR_WIDTH-1:0]   o_rs_pc;
  logic [DATA_WIDTH-1:0]   o_rs_insn;
  logic [TAG_WIDTH-1:0]    o_rs_dst_tag;

  modport slave (
    input  i_flush, i_dispatch_en, i_dispatch_opcode, i_dispatch_pc,
           i_dispatch_insn, i_dispatch_dst_tag, i_alu_rs_full, i_lsu_rs_full,
    output o_dispatch_stall, o_alu_rs_en, o_lsu_rs_en, o_rs_opcode, o_rs_pc,
           o_rs_insn, o_rs_dst_tag
  );

  modport master (
    output i_flush, i_dispatch_en, i_dispatch_opcode, i_dispatch_pc,
           i_dispatch_insn, i_dispatch_dst_tag, i_alu_rs_full, i_lsu_rs_full,
    input  o_dispatch_stall, o_alu_rs_en, o_lsu_rs_en, o_rs_opcode, o_rs_pc,
           o_rs_insn, o_rs_dst_tag
  );
endinterface

// File: rtl/dispatch_router.sv
// dispatch_router: one-entry holding register between map_dispatch and the
// reservation stations. Each captured instruction is classified as LSU
// (LOAD/STORE) or ALU and enqueued to the LSU station or to one of
// NUM_ALU_RS ALU stations chosen round-robin, skipping full ones. While the
// held instruction cannot be placed, o_dispatch_stall holds upstream.
// Ports:
//   clk   : clock
//   n_rst : synchronous active-low reset
//   bus   : dispatch_router_if.slave (dispatch inputs, station full flags,
//           enqueue strobes, shared payload bus, upstream stall)
module dispatch_router #(
  parameter int NUM_ALU_RS   = 2,
  parameter int OPCODE_WIDTH = 7,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  dispatch_router_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_ALU_RS);
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD  = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE = OPCODE_WIDTH'(7'b0100011);

  typedef enum logic {ST_EMPTY, ST_VALID} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   insn_q, insn_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic                    is_lsu_q, is_lsu_d;

  logic                    held;
  logic                    lsu_ok, alu_ok, fire;
  logic                    alu_free;
  logic [PTR_W-1:0]        sel;
  logic [PTR_W-1:0]        scan_idx;
  logic                    capture;

  function automatic logic classify_lsu(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

  // First non-full ALU station starting at rr_ptr; the pointer wraps
  // naturally because NUM_ALU_RS is a power of two.
  always_comb begin
    sel      = '0;
    alu_free = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_ALU_RS; i++) begin
      scan_idx = rr_ptr_q + PTR_W'(i);
      if (!alu_free && !bus.i_alu_rs_full[scan_idx]) begin
        sel      = scan_idx;
        alu_free = 1'b1;
      end
    end
  end

  assign held   = (state_q == ST_VALID);
  assign lsu_ok = held &  is_lsu_q & ~bus.i_lsu_rs_full;
  assign alu_ok = held & ~is_lsu_q & alu_free;
  assign fire   = (lsu_ok | alu_ok) & ~bus.i_flush;

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      opcode_q <= '0;
      pc_q     <= '0;
      insn_q   <= '0;
      tag_q    <= '0;
      is_lsu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      opcode_q <= opcode_d;
      pc_q     <= pc_d;
      insn_q   <= insn_d;
      tag_q    <= tag_d;
      is_lsu_q <= is_lsu_d;
    end
  end

  // Next-state logic. A flush empties the register without capturing;
  // a stalled entry ignores i_dispatch_en since upstream is held.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    capture  = 1'b0;
    if (bus.i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (bus.i_dispatch_en) begin
            capture = 1'b1;
            state_d = ST_VALID;
          end
        end
        ST_VALID: begin
          if (fire) begin
            capture = bus.i_dispatch_en;
            state_d = bus.i_dispatch_en ? ST_VALID : ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    if (alu_ok && !bus.i_flush) begin
      rr_ptr_d = sel + PTR_W'(1);
    end
    opcode_d = capture ? bus.i_dispatch_opcode  : opcode_q;
    pc_d     = capture ? bus.i_dispatch_pc      : pc_q;
    insn_d   = capture ? bus.i_dispatch_insn    : insn_q;
    tag_d    = capture ? bus.i_dispatch_dst_tag : tag_q;
    is_lsu_d = capture ? classify_lsu(bus.i_dispatch_opcode) : is_lsu_q;
  end

  // Output logic. The full flags reach o_dispatch_stall combinationally so
  // a station freeing up releases upstream in the same cycle.
  always_comb begin
    bus.o_lsu_rs_en      = lsu_ok & ~bus.i_flush;
    bus.o_alu_rs_en      = '0;
    if (alu_ok && !bus.i_flush) begin
      bus.o_alu_rs_en[sel] = 1'b1;
    end
    bus.o_dispatch_stall = held & ~fire & ~bus.i_flush;
  end

  assign bus.o_rs_opcode  = opcode_q;
  assign bus.o_rs_pc      = pc_q;
  assign bus.o_rs_insn    = insn_q;
  assign bus.o_rs_dst_tag = tag_q;
endmodule
